// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and width helpers.
// Imported by the elastic ALU pipeline and its slice.
package alu_pkg;

  typedef enum logic [2:0] {
    alu_and = 3'd0,
    alu_or  = 3'd1,
    alu_not = 3'd2,
    alu_add = 3'd3,
    alu_sub = 3'd4,
    alu_shl = 3'd5,
    alu_shr = 3'd6,
    alu_sra = 3'd7
  } aluop_t;

  localparam int unsigned OP_W = 3;

  function automatic int unsigned shamt_w(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/alu_pipe_slice.sv
// One elastic register stage: holds {valid, payload}.
// Loads whenever it is empty or the next stage advances.
module alu_pipe_slice #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [PW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [PW-1:0] data_o,
  input  logic          ready_i
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Elastic LAT-stage ALU: operand slice, op/flag logic,
// result slice, then pure delay slices up to LAT.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] f,
  output logic             zero_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned SH_W = shamt_w(WIDTH);
  localparam int unsigned P1_W = OP_W + 2*WIDTH + TAG_W;
  localparam int unsigned P2_W = WIDTH + 3 + TAG_W;

  logic [LAT+1:1]    rdy;
  logic [LAT:1]      vld;
  logic [P1_W-1:0]   s1_q;
  logic [P2_W-1:0]   din [2:LAT];
  logic [P2_W-1:0]   dq  [2:LAT];

  assign rdy[LAT+1] = ready_i;
  assign ready_o    = rdy[1];

  alu_pipe_slice #(.PW(P1_W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .data_i  ({aluop, a, b, tag_i}),
    .ready_o (rdy[1]),
    .valid_o (vld[1]),
    .data_o  (s1_q),
    .ready_i (rdy[2])
  );

  logic [2:0]       op_raw;
  aluop_t           op_s;
  logic [WIDTH-1:0] a_s, b_s;
  logic [TAG_W-1:0] tag_s;
  logic [SH_W-1:0]  sh;
  logic [WIDTH:0]   sum, dif;
  logic signed [WIDTH-1:0] a_sg;
  logic [WIDTH-1:0] res;
  logic             cy, ov;
  logic             a_msb, b_msb;

  assign {op_raw, a_s, b_s, tag_s} = s1_q;
  assign op_s  = aluop_t'(op_raw);
  assign sh    = b_s[SH_W-1:0];
  assign sum   = {1'b0, a_s} + {1'b0, b_s};
  assign dif   = {1'b0, a_s} - {1'b0, b_s};
  assign a_sg  = a_s;
  assign a_msb = a_s[WIDTH-1];
  assign b_msb = b_s[WIDTH-1];

  // dif[WIDTH] is set exactly when a < b unsigned (borrow)
  always_comb begin
    res = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    unique case (op_s)
      alu_and: res = a_s & b_s;
      alu_or:  res = a_s | b_s;
      alu_not: res = ~a_s;
      alu_add: begin
        res = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
        ov  = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);
      end
      alu_sub: begin
        res = dif[WIDTH-1:0];
        cy  = dif[WIDTH];
        ov  = (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
      end
      alu_shl: res = a_s << sh;
      alu_shr: res = a_s >> sh;
      alu_sra: res = a_sg >>> sh;
    endcase
  end

  for (genvar k = 2; k <= LAT; k++) begin : g_stage
    if (k == 2) begin : g_res
      assign din[k] = {res, (res == '0), cy, ov, tag_s};
    end else begin : g_dly
      assign din[k] = dq[k-1];
    end

    alu_pipe_slice #(.PW(P2_W)) u_s (
      .clk     (clk),
      .rst     (rst),
      .valid_i (vld[k-1]),
      .data_i  (din[k]),
      .ready_o (rdy[k]),
      .valid_o (vld[k]),
      .data_o  (dq[k]),
      .ready_i (rdy[k+1])
    );
  end

  assign {f, zero_o, carry_o, ovf_o, tag_o} = dq[LAT];
  assign valid_o = vld[LAT];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: 32-bit/LAT=2 and 8-bit/LAT=4
// instances checked against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int W8 = 8;
  localparam int L8 = 4;

  typedef struct packed {
    logic [31:0] f;
    logic        z;
    logic        c;
    logic        v;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [2:0]  aluop;
  logic [31:0] a, b, f;
  logic [3:0]  tag_i, tag_o;
  logic        valid_i, ready_o, zero_o, carry_o, ovf_o;
  logic        valid_o, ready_i;

  logic [2:0]  aluop8;
  logic [7:0]  a8, b8, f8;
  logic [3:0]  tag8_i, tag8_o;
  logic        valid8_i, ready8_o, zero8_o, carry8_o, ovf8_o;
  logic        valid8_o, ready8_i;

  alu_pipe #(.WIDTH(W), .LAT(L), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .aluop(aluop), .a(a), .b(b),
    .tag_i(tag_i), .valid_i(valid_i), .ready_o(ready_o),
    .f(f), .zero_o(zero_o), .carry_o(carry_o), .ovf_o(ovf_o),
    .tag_o(tag_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  alu_pipe #(.WIDTH(W8), .LAT(L8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .aluop(aluop8), .a(a8), .b(b8),
    .tag_i(tag8_i), .valid_i(valid8_i), .ready_o(ready8_o),
    .f(f8), .zero_o(zero8_o), .carry_o(carry8_o), .ovf_o(ovf8_o),
    .tag_o(tag8_o), .valid_o(valid8_o), .ready_i(ready8_i)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t q8[$];
  bit   done;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(int w, logic [2:0] op,
                                 logic [63:0] av, logic [63:0] bv,
                                 logic [3:0] t);
    exp_t        e;
    logic [63:0] m, ua, ub, r;
    longint      sa, sb, s, mx, mn;
    int          n;
    m  = (64'd1 << w) - 1;
    ua = av & m;
    ub = bv & m;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    mx = (longint'(1) << (w-1)) - 1;
    mn = -(longint'(1) << (w-1));
    n  = int'(ub % w);
    e  = '0;
    r  = '0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = ~ua & m;
      3'd3: begin
        r   = (ua + ub) & m;
        e.c = (ua + ub) > m;
        s   = sa + sb;
        e.v = (s > mx) || (s < mn);
      end
      3'd4: begin
        r   = (ua - ub) & m;
        e.c = ua < ub;
        s   = sa - sb;
        e.v = (s > mx) || (s < mn);
      end
      3'd5: r = (ua << n) & m;
      3'd6: r = ua >> n;
      default: r = 64'(sa >>> n) & m;
    endcase
    e.f   = r[31:0];
    e.z   = (r == 0);
    e.tag = t;
    return e;
  endfunction

  task automatic send(logic [2:0] op, logic [31:0] av,
                      logic [31:0] bv, logic [3:0] t);
    bit acc = 0;
    int g   = 0;
    aluop = op; a = av; b = bv; tag_i = t; valid_i = 1'b1;
    while (!acc && g < 300) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      g++;
    end
    if (acc) q.push_back(model(W, op, 64'(av), 64'(bv), t));
    else chk("send_timeout", 64'(acc), 64'd1);
    valid_i = 1'b0;
    a = $urandom;
    b = $urandom;
    aluop = 3'($urandom);
  endtask

  task automatic send8(logic [2:0] op, logic [7:0] av,
                       logic [7:0] bv, logic [3:0] t);
    bit acc = 0;
    int g   = 0;
    aluop8 = op; a8 = av; b8 = bv; tag8_i = t; valid8_i = 1'b1;
    while (!acc && g < 300) begin
      @(negedge clk);
      acc = ready8_o;
      @(posedge clk);
      #1;
      g++;
    end
    if (acc) q8.push_back(model(W8, op, 64'(av), 64'(bv), t));
    else chk("send8_timeout", 64'(acc), 64'd1);
    valid8_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ready_i = 1'b1;
    while ((q.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 64'(q.size() + q8.size()), 64'd0);
  endtask

  initial begin : mon32
    exp_t        e;
    bit          prev_stall = 0;
    logic [63:0] snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          chk("stall_hold",
              {f, zero_o, carry_o, ovf_o, tag_o, valid_o}, snap);
        if (valid_o && ready_i) begin
          if (q.size() == 0) begin
            chk("spurious_out", 64'(valid_o), 64'd0);
          end else begin
            e = q.pop_front();
            chk("result32", {f, zero_o, carry_o, ovf_o, tag_o},
                {e.f, e.z, e.c, e.v, e.tag});
          end
        end
        prev_stall = valid_o && !ready_i;
        snap = {f, zero_o, carry_o, ovf_o, tag_o, valid_o};
      end
    end
  end

  initial begin : mon8
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid8_o && ready8_i) begin
        if (q8.size() == 0) begin
          chk("spurious_out8", 64'(valid8_o), 64'd0);
        end else begin
          e = q8.pop_front();
          chk("result8", {f8, zero8_o, carry8_o, ovf8_o, tag8_o},
              {e.f[7:0], e.z, e.c, e.v, e.tag});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    aluop = '0; a = '0; b = '0; tag_i = '0;
    valid_i = 1'b0; ready_i = 1'b1;
    aluop8 = '0; a8 = '0; b8 = '0; tag8_i = '0;
    valid8_i = 1'b0; ready8_i = 1'b1;
    done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_out32", {f, zero_o, carry_o, ovf_o, tag_o, valid_o}, 0);
    chk("reset_rdy32", 64'(ready_o), 64'd1);
    chk("reset_out8",
        {f8, zero8_o, carry8_o, ovf8_o, tag8_o, valid8_o}, 0);
    chk("reset_rdy8", 64'(ready8_o), 64'd1);
    @(posedge clk);
    #1;

    send(3'd3, 32'h7FFF_FFFF, 32'd1, 4'd3);
    @(negedge clk);
    chk("lat2_early", 64'(valid_o), 64'd0);
    @(negedge clk);
    chk("lat2_valid", 64'(valid_o), 64'd1);
    @(posedge clk);
    #1;
    send(3'd4, 32'd5, 32'd7, 4'd4);
    send(3'd4, 32'd9, 32'd9, 4'd5);
    send(3'd7, 32'h8000_0010, 32'h24, 4'd6);
    send(3'd6, 32'h8000_0010, 32'h24, 4'd7);
    send(3'd2, 32'd0, 32'h1234, 4'd8);
    send(3'd5, 32'h1234_5678, 32'h20, 4'd9);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++)
          send(3'd3, $urandom, $urandom, 4'(i));
      end
      begin
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("full_ready_o", 64'(ready_o), 64'd0);
        chk("full_occupancy", 64'(q.size()), 64'(L));
        @(posedge clk);
        #1 ready_i = 1'b1;
        @(negedge clk);
        chk("release_ready_o", 64'(ready_o), 64'd1);
      end
    join
    drain();

    ready_i = 1'b0;
    send(3'd3, 32'd1, 32'd2, 4'd10);
    send(3'd4, 32'd8, 32'd3, 4'd11);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_mid_valid", 64'(valid_o), 64'd0);
    chk("rst_mid_f", 64'(f), 64'd0);
    chk("rst_mid_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 ready_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] av, bv;
          int          g;
          case ($urandom_range(0, 3))
            0: av = 32'h7FFF_FFFF;
            1: av = 32'h8000_0000;
            default: av = $urandom;
          endcase
          bv = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
          send(3'($urandom), av, bv, 4'($urandom));
          g = $urandom_range(0, 2);
          if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    drain();

    send8(3'd3, 8'hFF, 8'h01, 4'd5);
    repeat (L8 - 1) begin
      @(negedge clk);
      chk("lat4_early", 64'(valid8_o), 64'd0);
    end
    @(negedge clk);
    chk("lat4_valid", 64'(valid8_o), 64'd1);
    @(posedge clk);
    #1;
    send8(3'd5, 8'h81, 8'h09, 4'd6);
    for (int i = 0; i < 40; i++)
      send8(3'($urandom), 8'($urandom), 8'($urandom), 4'(i));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
